// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard and decode stall request.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic             rd_use_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             busy_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             rd_use_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             stall,
  output logic [AW:0]      pending_count
);

  localparam int CW = AW + 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [CW-1:0]    count_next;
  logic             wr_live;
  logic             issue_live;

  assign wr_live    = wr_en && (wr_addr != '0);
  assign issue_live = issue_en && (issue_addr != '0);

  // Issue is applied after the write clear: a same-cycle issue is the newer producer.
  always_comb begin
    busy_next = busy;
    if (wr_live)    busy_next[wr_addr]    = 1'b0;
    if (issue_live) busy_next[issue_addr] = 1'b1;
  end

  always_comb begin
    count_next = '0;
    for (int i = 1; i < DEPTH; i++) begin
      count_next = count_next + CW'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy          <= '0;
      pending_count <= '0;
    end else begin
      if (wr_live) regs[wr_addr] <= wr_data;
      busy          <= busy_next;
      pending_count <= count_next;
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    busy_a    = busy[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    busy_b    = busy[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Forward the writeback in flight; a same-cycle issue only shows from the next cycle.
    if (wr_live && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      busy_a    = 1'b0;
    end
    if (wr_live && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      busy_b    = 1'b0;
    end
`endif
  end

  assign stall = (busy_a & rd_use_a) | (busy_b & rd_use_b);

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated pending-write scoreboard, replacing the flat 32×32 register file in the pipelined MIPS core. It provides two asynchronous read ports, one synchronous write port, a hard-wired zero register, per-register busy tracking for in-flight destination writes, and a stall request for the decode stage. It sits between decode (issue, read) and writeback (write).

## Interface

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr_a  in  AW  read port A address
- rd_use_a  in  1  decode actually consumes port A this cycle
- rd_data_a  out  WIDTH  read port A data
- busy_a  out  1  register at rd_addr_a has a pending write
- rd_addr_b  in  AW  read port B address
- rd_use_b  in  1  decode actually consumes port B this cycle
- rd_data_b  out  WIDTH  read port B data
- busy_b  out  1  register at rd_addr_b has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  WIDTH  writeback data
- issue_en  in  1  an instruction with a destination register leaves decode
- issue_addr  in  AW  its destination register
- stall  out  1  decode must hold: (busy_a & rd_use_a) | (busy_b & rd_use_b)
- pending_count  out  AW+1  number of registers currently marked busy

## Operation

- Storage: DEPTH × WIDTH registers plus a DEPTH-bit busy vector.
- Reset (rst_n low, asynchronous): all registers cleared to 0, all busy bits cleared, pending_count = 0. Hence rd_data_a/b = 0, busy_a/b = 0, stall = 0 during and immediately after reset.
- Register 0: reads always return 0. Writes and issues to address 0 are ignored. It is never busy.
- Write: on posedge, if wr_en and wr_addr ≠ 0, the register is set to wr_data and its busy bit is cleared.
- Issue: on posedge, if issue_en and issue_addr ≠ 0, the busy bit is set.
- Same address issued and written in one cycle: the data is written and the busy bit stays set, because the issue is the newer producer.
- Issue to an already-busy register (WAW): the bit stays set and pending_count is unchanged.
- Write to a non-busy register: legal. Data is written and pending_count is unchanged.
- pending_count is the registered popcount of the busy vector. It updates on the same edge as the busy bits and never exceeds DEPTH−1.
- Reads are combinational from the address. The two ports are fully independent and may use the same address.
- stall is purely combinational from the busy_x and rd_use_x signals. A busy register that is not used does not stall.

## Timing

- Read latency: 0 cycles (combinational).
- Write visibility without bypass: new data appears on rd_data the cycle after the wr_en edge, and busy clears at the same point.
- Issue visibility: busy_x rises the cycle after the issue_en edge.
- Reset asserted mid-operation clears all state immediately, regardless of clk. The first edge after rst_n deasserts performs a normal update.
- Inputs must be stable around the posedge. Port outputs glitch only with their addresses and with wr_* (bypass).

## Configuration

- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding.
  - If wr_en and wr_addr == rd_addr_x ≠ 0, then rd_data_x = wr_data and busy_x = 0 in that same cycle.
  - An issue in that same cycle to the same address does not affect the current-cycle busy_x.
  - This removes one stall cycle per RAW hazard.
- REGFILE_BYPASS_EN undefined: no forwarding. rd_data_x and busy_x reflect stored state only, so writeback takes effect one cycle later.

## Test plan

- Reset, then read every address on both ports: all rd_data = 0, busy = 0, stall = 0, pending_count = 0.
- Write 0xDEADBEEF to r0 with issue_en to r0 in the same cycle: r0 reads 0, busy_a(r0) = 0, pending_count = 0.
- Issue r5, then set rd_addr_a = 5 with rd_use_a = 1: busy_a = 1 and stall = 1, but stall = 0 when rd_use_a = 0. Write 0x1234 to r5:
  - Bypass build: in the write cycle rd_data_a = 0x1234, busy_a = 0, stall = 0.
  - Non-bypass build: the same values appear one cycle later.
- Issue and write r7 in the same cycle (data 0x55): afterwards r7 reads 0x55, busy = 1, pending_count = 1.
- Issue r1, r2, r3 on successive cycles, then r2 again: pending_count goes 1, 2, 3, 3. Write r2 and then r1: pending_count goes 2, 1.
- Pulse rst_n low between clock edges with three registers busy: pending_count and busy drop to 0 and data reads 0 immediately, before the next clk edge.
